// File: rtl/fetch_bundle_pkg.sv
// Shared constants and types for the VLIW fetch stage: opcode/register encodings
// and the per-slot opcode/destination record.
package fetch_bundle_pkg;

  localparam int NUM_SLOTS = 3;
  localparam int LIT_W     = 64;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] REG0    = 4'h0;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] dst;
  } slot_t;

  // Slot number 1..NUM_SLOTS; 0 means "none" / "before the first slot".
  typedef logic [1:0] slot_idx_t;

  localparam slot_t SLOT_NOP = '{op: OP_NOP, dst: REG0};

  // A nop never writes a register, whatever its dest field says.
  function automatic slot_t slot_out(slot_t s);
    slot_t r;
    r.op  = s.op;
    r.dst = (s.op == OP_NOP) ? REG0 : s.dst;
    return r;
  endfunction

endpackage

// File: rtl/fetch_slot_unpack.sv
// Splits a bundle header word into its three opcode/dest pairs and locates the
// load slots, whose literals follow the header in slot order.
module fetch_slot_unpack
  import fetch_bundle_pkg::*;
(
  input  logic [LIT_W-1:0]           hdr,
  input  slot_idx_t                  after_slot,
  output slot_t     [NUM_SLOTS-1:0]  slots,
  output logic      [NUM_SLOTS-1:0]  load_mask,
  output logic      [1:0]            load_cnt,
  output slot_idx_t                  next_slot
);

  logic unused_hdr;
  assign unused_hdr = ^hdr[LIT_W-1:24];

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign slots[i]     = slot_t'(hdr[23-8*i -: 8]);
    assign load_mask[i] = (hdr[23-8*i -: 4] == OP_LOAD);
  end

  always_comb begin
    load_cnt  = '0;
    next_slot = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      load_cnt = load_cnt + 2'(load_mask[i]);
    // walk downwards so the lowest qualifying slot wins
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (load_mask[i] && ((i + 1) > int'(after_slot)))
        next_slot = slot_idx_t'(i + 1);
  end

endmodule

// File: rtl/fetch_bundle.sv
// VLIW fetch stage: walks header + literal words over a req/ack memory port and
// presents one complete bundle per issue cycle to decode, nops otherwise.
module fetch_bundle
  import fetch_bundle_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [LIT_W-1:0]  imem_rdata,
  output logic [3:0]        f2dr_instpipe1,
  output logic [3:0]        f2dr_instpipe2,
  output logic [3:0]        f2dr_instpipe3,
  output logic [3:0]        f2d_destpipe1,
  output logic [3:0]        f2d_destpipe2,
  output logic [3:0]        f2d_destpipe3,
  output logic [191:0]      f2d_data,
  output logic [PC_W-1:0]   fetch_pc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_LIT   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]                         state;
  logic [PC_W-1:0]                    pc, redir, drain_addr;
  logic [1:0]                         k;
  slot_idx_t                          cur_slot;
  logic [LIT_W-1:0]                   hdr_q;
  logic [NUM_SLOTS-1:0][LIT_W-1:0]    lit_q;

  slot_t [NUM_SLOTS-1:0]              out_slot, nxt_slot;
  logic  [NUM_SLOTS-1:0][LIT_W-1:0]   out_data, nxt_data;
  logic                               issue;

  slot_t [NUM_SLOTS-1:0]              rd_slots, q_slots;
  logic  [NUM_SLOTS-1:0]              rd_mask, q_mask;
  logic  [1:0]                        rd_cnt, q_cnt;
  slot_idx_t                          rd_next, q_next;

  // rd decodes the header arriving now; q decodes the captured one during literals
  fetch_slot_unpack u_unpack_rd (
    .hdr(imem_rdata), .after_slot(slot_idx_t'(0)),
    .slots(rd_slots), .load_mask(rd_mask), .load_cnt(rd_cnt), .next_slot(rd_next)
  );

  fetch_slot_unpack u_unpack_q (
    .hdr(hdr_q), .after_slot(cur_slot),
    .slots(q_slots), .load_mask(q_mask), .load_cnt(q_cnt), .next_slot(q_next)
  );

  logic unused_rd_mask;
  assign unused_rd_mask = ^rd_mask;

  logic hdr_ack, lit_ack, last_lit;
  assign hdr_ack  = (state == S_HDR) && imem_ack;
  assign lit_ack  = (state == S_LIT) && imem_ack;
  assign last_lit = lit_ack && ((k + 2'd1) == q_cnt);

  assign imem_req = (state != S_IDLE);

  always_comb begin
    case (state)
      S_LIT:   imem_addr = pc + PC_W'(1) + PC_W'(k);
      S_DRAIN: imem_addr = drain_addr;
      default: imem_addr = pc;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      nxt_slot[i] = SLOT_NOP;
      nxt_data[i] = '0;
    end
    if (hdr_ack && (rd_cnt == 2'd0)) begin
      issue = 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++)
        nxt_slot[i] = slot_out(rd_slots[i]);
    end else if (last_lit) begin
      issue = 1'b1;
      // the final literal is still on the bus; earlier ones sit in lit_q
      for (int i = 0; i < NUM_SLOTS; i++) begin
        nxt_slot[i] = slot_out(q_slots[i]);
        if (q_mask[i])
          nxt_data[i] = (slot_idx_t'(i + 1) == cur_slot) ? imem_rdata : lit_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      redir      <= '0;
      drain_addr <= '0;
      k          <= '0;
      cur_slot   <= '0;
      hdr_q      <= '0;
      lit_q      <= '0;
    end else if (flush) begin
      k        <= '0;
      cur_slot <= '0;
      lit_q    <= '0;
      redir    <= redirect_pc;
      if (imem_req && !imem_ack) begin
        // the outstanding request must still complete; keep presenting its address
        state      <= S_DRAIN;
        drain_addr <= imem_addr;
      end else begin
        state <= S_HDR;
        pc    <= redirect_pc;
      end
    end else begin
      case (state)
        S_IDLE: state <= S_HDR;
        S_HDR: begin
          if (imem_ack) begin
            if (rd_cnt == 2'd0) begin
              pc <= pc + PC_W'(1);
            end else begin
              hdr_q    <= imem_rdata;
              k        <= '0;
              cur_slot <= rd_next;
              state    <= S_LIT;
            end
          end
        end
        S_LIT: begin
          if (imem_ack) begin
            lit_q[cur_slot - 2'd1] <= imem_rdata;
            if (last_lit) begin
              pc       <= pc + PC_W'(1) + PC_W'(q_cnt);
              k        <= '0;
              cur_slot <= '0;
              state    <= S_HDR;
            end else begin
              k        <= k + 2'd1;
              cur_slot <= q_next;
            end
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            pc    <= redir;
            state <= S_HDR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A bundle is visible for exactly the cycle after its final ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        out_slot[i] <= SLOT_NOP;
        out_data[i] <= '0;
      end
      fetch_pc <= RESET_PC;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        out_slot[i] <= flush ? SLOT_NOP : nxt_slot[i];
        out_data[i] <= flush ? '0 : nxt_data[i];
      end
      if (issue && !flush)
        fetch_pc <= pc;
    end
  end

  assign f2dr_instpipe1 = out_slot[0].op;
  assign f2dr_instpipe2 = out_slot[1].op;
  assign f2dr_instpipe3 = out_slot[2].op;
  assign f2d_destpipe1  = out_slot[0].dst;
  assign f2d_destpipe2  = out_slot[1].dst;
  assign f2d_destpipe3  = out_slot[2].dst;
  assign f2d_data       = {out_data[0], out_data[1], out_data[2]};

endmodule

// File: tb/tb_fetch_bundle.sv
// Directed bench for fetch_bundle: table of bundles walked through a latency-
// configurable memory model, plus flush / wrap / reset sequences.
module tb_fetch_bundle;
  import fetch_bundle_pkg::*;

  logic         clock = 1'b0, reset = 1'b1, flush = 1'b0;
  logic [15:0]  redirect_pc = '0;
  logic         imem_req, imem_ack;
  logic [15:0]  imem_addr;
  logic [63:0]  imem_rdata;
  logic [3:0]   op1, op2, op3, d1, d2, d3;
  logic [191:0] f2d_data;
  logic [15:0]  fetch_pc;

  fetch_bundle #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .f2dr_instpipe1(op1), .f2dr_instpipe2(op2), .f2dr_instpipe3(op3),
    .f2d_destpipe1(d1), .f2d_destpipe2(d2), .f2d_destpipe3(d3),
    .f2d_data(f2d_data), .fetch_pc(fetch_pc)
  );

  always #5 clock = ~clock;

  // memory: ack after lat waiting cycles (lat=0 acks in the request cycle)
  logic [63:0] mem [0:65535];
  int lat = 1;
  int wait_cnt = 0;
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = mem[imem_addr];
  always @(posedge clock)
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // request must stay put until acked
  logic p_req = 1'b0, p_ack = 1'b1, p_rst = 1'b0;
  logic [15:0] p_addr = '0;
  always @(negedge clock) begin
    if (p_rst && reset && p_req && !p_ack)
      chk("addr_hold", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, p_addr});
    p_req  <= imem_req;
    p_ack  <= imem_ack;
    p_addr <= imem_addr;
    p_rst  <= reset;
  end

  typedef struct packed {
    logic [11:0]  ops;
    logic [11:0]  dsts;
    logic [191:0] data;
    logic [15:0]  fpc;
    logic [15:0]  addr;
  } cap_t;
  cap_t capq[$];
  bit cap_en = 1'b0;
  always @(negedge clock)
    if (cap_en && reset && ({op1, op2, op3} != 12'h000))
      capq.push_back('{ops: {op1, op2, op3}, dsts: {d1, d2, d3}, data: f2d_data,
                       fpc: fetch_pc, addr: imem_addr});

  typedef struct packed {
    logic [15:0]       pc;
    logic [63:0]       hdr;
    logic [1:0]        nlit;
    logic [2:0][63:0]  lit;
    logic [11:0]       ops;
    logic [11:0]       dsts;
    logic [191:0]      data;
    logic [15:0]       nxt;
  } vec_t;
  vec_t tbl [6];

  localparam logic [63:0] L2  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] L4  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] L6  = 64'hA1A1_0000_0000_0006;
  localparam logic [63:0] L7  = 64'hA2A2_0000_0000_0007;
  localparam logic [63:0] L8  = 64'hA3A3_0000_0000_0008;
  localparam logic [63:0] L10 = 64'hC0DE_0000_0000_000A;
  localparam logic [63:0] L11 = 64'hC0DE_0000_0000_000B;

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic hold_reset(input int l);
    reset = 1'b0;
    flush = 1'b0;
    lat   = l;
    repeat (2) tick();
    capq.delete();
  endtask

  task automatic run_table(input int l);
    int c;
    hold_reset(l);
    chk("rst_req", {191'd0, imem_req}, 192'd0);
    chk("rst_ops", {180'd0, op1, op2, op3, d1, d2, d3}, 192'd0);
    chk("rst_data", f2d_data, 192'd0);
    chk("rst_fpc", {176'd0, fetch_pc}, 192'd0);
    reset = 1'b1;
    chk("idle_req", {191'd0, imem_req}, 192'd0);
    tick();
    chk("first_req", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, 16'h0000});
    for (c = 0; c < 300 && capq.size() < 6; c++) tick();
    chk("tbl_count", 192'(capq.size() >= 6), 192'd1);
    for (int i = 0; i < 6 && i < capq.size(); i++) begin
      chk($sformatf("tbl%0d_ops", i),  192'(capq[i].ops),  192'(tbl[i].ops));
      chk($sformatf("tbl%0d_dsts", i), 192'(capq[i].dsts), 192'(tbl[i].dsts));
      chk($sformatf("tbl%0d_data", i), capq[i].data,       tbl[i].data);
      chk($sformatf("tbl%0d_fpc", i),  192'(capq[i].fpc),  192'(tbl[i].pc));
      chk($sformatf("tbl%0d_next", i), 192'(capq[i].addr), 192'(tbl[i].nxt));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    bit seen30;
    for (int a = 0; a < 65536; a++) mem[a] = 64'h0;
    tbl[0] = '{pc: 16'd0,  hdr: 64'hFFFF_FFFF_FF21_3205, nlit: 2'd0, lit: '0,
               ops: 12'h230, dsts: 12'h120, data: '0, nxt: 16'd1};
    tbl[1] = '{pc: 16'd1,  hdr: 64'h29132A, nlit: 2'd1, lit: {64'h0, 64'h0, L2},
               ops: 12'h212, dsts: 12'h93A, data: {64'h0, L2, 64'h0}, nxt: 16'd3};
    tbl[2] = '{pc: 16'd3,  hdr: 64'h07241B, nlit: 2'd1, lit: {64'h0, 64'h0, L4},
               ops: 12'h021, dsts: 12'h04B, data: {64'h0, 64'h0, L4}, nxt: 16'd5};
    tbl[3] = '{pc: 16'd5,  hdr: 64'h111213, nlit: 2'd3, lit: {L8, L7, L6},
               ops: 12'h111, dsts: 12'h123, data: {L6, L7, L8}, nxt: 16'd9};
    tbl[4] = '{pc: 16'd9,  hdr: 64'h163718, nlit: 2'd2, lit: {64'h0, L11, L10},
               ops: 12'h131, dsts: 12'h678, data: {L10, 64'h0, L11}, nxt: 16'd12};
    tbl[5] = '{pc: 16'd12, hdr: 64'h3F000C, nlit: 2'd0, lit: '0,
               ops: 12'h300, dsts: 12'hF00, data: '0, nxt: 16'd13};
    for (int i = 0; i < 6; i++) begin
      mem[tbl[i].pc] = tbl[i].hdr;
      for (int j = 0; j < int'(tbl[i].nlit); j++)
        mem[16'(tbl[i].pc + 16'(j + 1))] = tbl[i].lit[j];
    end
    #1 reset = 1'b0;
    cap_en = 1'b1;

    run_table(1);
    run_table(0);

    // flush while a literal is outstanding, re-flushed during the drain
    hold_reset(4);
    mem[16'h20] = 64'h150000;
    mem[16'h21] = 64'h5555_0000_0000_0021;
    mem[16'h40] = 64'h2E0000;
    reset = 1'b1; flush = 1'b1; redirect_pc = 16'h0020;
    tick();
    flush = 1'b0;
    chk("idle_flush_addr", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, 16'h0020});
    for (c = 0; c < 50 && !(imem_req && imem_addr == 16'h0021); c++) tick();
    chk("lit_req_seen", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, 16'h0021});
    tick();
    flush = 1'b1; redirect_pc = 16'h0030;
    tick();
    redirect_pc = 16'h0040;
    chk("drain_hold", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, 16'h0021});
    chk("drain_ops", {180'd0, op1, op2, op3, d1, d2, d3}, 192'd0);
    tick();
    flush = 1'b0;
    seen30 = 1'b0;
    for (c = 0; c < 50 && !(imem_req && imem_addr == 16'h0040); c++) begin
      if (imem_req && imem_addr == 16'h0030) seen30 = 1'b1;
      tick();
    end
    chk("redirect_addr", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, 16'h0040});
    chk("stale_redirect", 192'(seen30), 192'd0);
    chk("flush_no_issue", 192'(capq.size()), 192'd0);
    for (c = 0; c < 50 && capq.size() < 1; c++) tick();
    chk("redir_issue", 192'(capq.size() >= 1), 192'd1);
    if (capq.size() >= 1) begin
      chk("redir_ops", 192'({capq[0].ops, capq[0].dsts}), 192'(24'h200E00));
      chk("redir_fpc", 192'(capq[0].fpc), 192'(16'h0040));
    end

    // flush on the same edge as a final ack
    hold_reset(2);
    mem[16'h60] = 64'h210000;
    mem[16'h70] = 64'h220000;
    reset = 1'b1; flush = 1'b1; redirect_pc = 16'h0060;
    tick();
    flush = 1'b0;
    for (c = 0; c < 50 && !(imem_ack && imem_addr == 16'h0060); c++) tick();
    chk("final_ack_seen", {175'd0, imem_ack, imem_addr}, {175'd0, 1'b1, 16'h0060});
    capq.delete();
    flush = 1'b1; redirect_pc = 16'h0070;
    tick();
    flush = 1'b0;
    chk("coinc_ops", {180'd0, op1, op2, op3, d1, d2, d3}, 192'd0);
    chk("coinc_data", f2d_data, 192'd0);
    chk("coinc_next", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, 16'h0070});
    for (c = 0; c < 50 && capq.size() < 1; c++) tick();
    chk("coinc_issue", 192'(capq.size() >= 1), 192'd1);
    if (capq.size() >= 1) begin
      chk("coinc_fpc", 192'(capq[0].fpc), 192'(16'h0070));
      chk("coinc_bundle", 192'({capq[0].ops, capq[0].dsts}), 192'(24'h200200));
    end

    // address wrap, then reset in the middle of a literal request
    hold_reset(1);
    mem[16'hFFFF] = 64'h200019;
    mem[16'h0000] = 64'h7777_0000_0000_FFFF;
    reset = 1'b1; flush = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    flush = 1'b0;
    for (c = 0; c < 50 && !(imem_req && imem_addr == 16'h0000); c++) tick();
    chk("wrap_lit_addr", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, 16'h0000});
    for (c = 0; c < 50 && capq.size() < 1; c++) tick();
    chk("wrap_issue", 192'(capq.size() >= 1), 192'd1);
    if (capq.size() >= 1) begin
      chk("wrap_fpc", 192'(capq[0].fpc), 192'(16'hFFFF));
      chk("wrap_bundle", 192'({capq[0].ops, capq[0].dsts}), 192'(24'h201009));
      chk("wrap_data", capq[0].data, {64'h0, 64'h0, 64'h7777_0000_0000_FFFF});
      chk("wrap_next", 192'(capq[0].addr), 192'(16'h0001));
    end
    for (c = 0; c < 50 && !(imem_req && imem_addr == 16'h0002); c++) tick();
    chk("mid_lit_seen", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, 16'h0002});
    reset = 1'b0;
    #1;
    chk("async_rst_req", {191'd0, imem_req}, 192'd0);
    chk("async_rst_ops", {180'd0, op1, op2, op3, d1, d2, d3}, 192'd0);
    chk("async_rst_fpc", {176'd0, fetch_pc}, 192'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("restart_addr", {175'd0, imem_req, imem_addr}, {175'd0, 1'b1, 16'h0000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
